branch_pc_unit: RTL
===================

# branch_pc_unit

Program-counter and next-PC stage that sits directly downstream of the branch comparator: it consumes the comparator's `cmp_res` together with the EX-stage control-flow information. It owns the architectural fetch PC and resolves branch/JAL/JALR redirects. It also drives the instruction-fetch request handshake toward instruction memory, and signals IF/ID flush and wrong-path kill.

## Interface
Parameters
- `RESET_PC`, `64'h0`: PC value loaded on reset.

Ports
- `clk`  in  1  core clock; everything updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard stall from the pipeline; holds the PC.
- `br_valid`  in  1  the EX stage holds a valid instruction.
- `npc_sel`  in  `npc_sel_enum` (2)  `NPC_SEQ`, `NPC_BR`, `NPC_JAL` or `NPC_JALR`.
- `cmp_res`  in  1  comparator result for the EX instruction.
- `ex_pc`  in  64  PC of the EX instruction.
- `imm`  in  64  sign-extended immediate.
- `rs1`  in  64  rs1 operand, used by JALR.
- `if_req_valid`  out  1  fetch request valid.
- `if_req_addr`  out  64  fetch address.
- `if_req_ready`  in  1  the instruction memory accepts the request.
- `if_kill`  out  1  the request accepted this cycle is wrong-path; the IF stage discards its response.
- `flush`  out  1  kill the IF/ID contents; one-cycle pulse.
- `misalign_exc`  out  1  a taken target is not 4-byte aligned.
- `pc`  out  64  current PC register.

## Operation
- Taken condition: `br_valid` and any of
  - `npc_sel==NPC_BR` with `cmp_res`
  - `NPC_JAL`
  - `NPC_JALR`
- Target:
  - BR/JAL: `ex_pc+imm`, modulo 2^64.
  - JALR: `(rs1+imm) & ~64'h1`.
- `misalign_exc` = taken and `target[1]`. Both are combinational.
  - When `misalign_exc` is set there is no redirect and no `flush`, and the PC is not changed.
- `redirect` = taken and no misalignment. `flush` = `redirect`, combinational, in the same cycle.
- `lock` register: set when `if_req_valid` is high and `if_req_ready` is low; cleared on `if_req_ready`.
  - While the request is locked, `if_req_addr` is stable and `if_req_valid` stays high.
- `if_req_valid` = (state != `BOOT`) and (`!stall` or `lock`). `if_req_addr` = `pc`.
- FSM states:
  - `BOOT`: entered on reset. `if_req_valid=0`. Goes to `RUN` on the next cycle.
  - `RUN`, per cycle in this priority order:
    1. `redirect` and `lock` and not ready: save the target in `redir_q`; go to `HOLD_REDIR`.
    2. `redirect` otherwise: `pc<=target`. `if_kill` = `if_req_valid & if_req_ready`.
    3. Accept (valid and ready): `pc<=pc+4`.
    4. Otherwise: hold.
  - A redirect overrides `stall`.
  - `HOLD_REDIR`: the locked request continues to be presented. On `if_req_ready`: `if_kill=1`, `pc<=redir_q`, go to `RUN`.
    - `br_valid` is ignored in this state; EX holds a bubble after `flush`.
- Reset values:
  - `pc=RESET_PC`, state `BOOT`, `lock=0`, `redir_q=0`.
  - Outputs: `if_req_valid=0`, `if_kill=0`. `flush` and `misalign_exc` are combinational; the testbench drives `br_valid=0` during reset.
  - `rst` mid-request abandons the locked request; the memory side is reset in the same cycle.

## Timing
- Sequential fetch: one new address per cycle while `if_req_ready` stays high.
- Redirect latency:
  - Unlocked: the target appears on `if_req_addr` one cycle after the redirect cycle.
  - Locked: the target appears one cycle after the stale request is accepted.
- Stall: while `stall` is high and nothing is locked, `if_req_valid` is 0 and `pc` is held. If a stall begins while a request is locked, that request is held until it is accepted, then `pc` advances by 4.
- Flush, exception and kill are single-cycle pulses with no internal latency.

## Structure
- The following go in `CorePack`:
  - `npc_sel_enum` and `pc_state_enum` {`BOOT`, `RUN`, `HOLD_REDIR`}
  - `addr_t`, reused as 64-bit
  - constant `INST_BYTES=4`
- One sub-module, `npc_target`: purely combinational target, taken and misalignment computation.
- The parent module holds the PC, the lock register, `redir_q` and the FSM.

## Test plan
- Reset, then `if_req_ready=1`, no branches: addresses 0x0, 0x4, 0x8, 0xC on consecutive cycles; `if_req_valid=0` in the `BOOT` cycle.
- `NPC_BR` with `ex_pc=0x10`, `imm=0x20`, `cmp_res=1`, ready high: `flush=1` and `if_kill=1` that cycle; next address 0x30. With `cmp_res=0`: no flush, sequential fetch continues.
- JALR with `rs1=0x101`, `imm=0x4`: next address 0x104. JAL with `ex_pc=0x8`, `imm=0x6`: `misalign_exc=1`, no flush, PC unchanged.
- Ready held low for 3 cycles at address 0x40, redirect to 0x80 in the first of those cycles: address stays 0x40 until ready; `if_kill=1` on the accept; next address 0x80; later `br_valid` pulses during `HOLD_REDIR` are ignored.
- `stall=1` for 2 cycles with no lock: `if_req_valid=0`, PC held. Stall asserted together with a redirect: the redirect wins.
- `rst` asserted during `HOLD_REDIR`: next cycle `pc=RESET_PC`, `if_req_valid=0`, FSM in `BOOT`.

Source files
------------

// File: rtl/branch_pc_unit_pkg.sv
// CorePack: shared types and constants for the PC / next-PC stage
package CorePack;
    typedef logic [63:0] addr_t;
    typedef enum logic [1:0] {NPC_SEQ, NPC_BR, NPC_JAL, NPC_JALR} npc_sel_enum;
    typedef enum logic [1:0] {BOOT, RUN, HOLD_REDIR} pc_state_enum;
    localparam addr_t INST_BYTES = 64'd4;
endpackage

// File: rtl/branch_pc_unit_npc_target.sv
// npc_target: combinational branch target, taken and misalignment decode
// ports: br_valid/npc_sel/cmp_res/ex_pc/imm/rs1 in; target/taken/misalign out
module npc_target
    import CorePack::*;
(
    input  logic        br_valid,
    input  npc_sel_enum npc_sel,
    input  logic        cmp_res,
    input  addr_t       ex_pc,
    input  addr_t       imm,
    input  addr_t       rs1,
    output addr_t       target,
    output logic        taken,
    output logic        misalign
);
    always_comb begin
        target   = npc_sel == NPC_JALR ? (rs1 + imm) & ~64'h1 : ex_pc + imm;
        taken    = br_valid & ((npc_sel == NPC_BR & cmp_res) | npc_sel == NPC_JAL | npc_sel == NPC_JALR);
        misalign = taken & target[1];
    end
endmodule

// File: rtl/branch_pc_unit.sv
// branch_pc_unit: fetch PC register, redirect resolution and IF request handshake
// ports: clk/rst; stall; EX control flow (br_valid, npc_sel, cmp_res, ex_pc, imm, rs1);
//        IF request (if_req_valid, if_req_addr, if_req_ready, if_kill); flush, misalign_exc, pc
module branch_pc_unit
    import CorePack::*;
#(
    parameter addr_t RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_valid,
    input  npc_sel_enum npc_sel,
    input  logic        cmp_res,
    input  addr_t       ex_pc,
    input  addr_t       imm,
    input  addr_t       rs1,
    output logic        if_req_valid,
    output addr_t       if_req_addr,
    input  logic        if_req_ready,
    output logic        if_kill,
    output logic        flush,
    output logic        misalign_exc,
    output addr_t       pc
);
    pc_state_enum state, state_n;
    addr_t        pc_n, redir_q, redir_n, target;
    logic         lock, taken, redirect, pending;

    // EX is only trusted in RUN; after a flush it holds a bubble
    npc_target u_tgt (
        .br_valid(br_valid & state == RUN),
        .npc_sel (npc_sel),
        .cmp_res (cmp_res),
        .ex_pc   (ex_pc),
        .imm     (imm),
        .rs1     (rs1),
        .target  (target),
        .taken   (taken),
        .misalign(misalign_exc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= BOOT;
            pc      <= RESET_PC;
            lock    <= 1'b0;
            redir_q <= '0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            lock    <= if_req_valid & ~if_req_ready;
            redir_q <= redir_n;
        end
    end

    always_comb begin
        redirect     = taken & ~misalign_exc;
        flush        = redirect;
        if_req_valid = state != BOOT & (~stall | lock);
        if_req_addr  = pc;
        // an unaccepted request must keep its address, so a redirect waits behind it
        pending      = if_req_valid & ~if_req_ready;
        state_n      = state;
        pc_n         = pc;
        redir_n      = redir_q;
        if_kill      = 1'b0;
        if (state == BOOT) begin
            state_n = RUN;
        end else if (state == HOLD_REDIR) begin
            if (if_req_ready) begin
                if_kill = 1'b1;
                pc_n    = redir_q;
                state_n = RUN;
            end
        end else if (redirect & pending) begin
            redir_n = target;
            state_n = HOLD_REDIR;
        end else if (redirect) begin
            pc_n    = target;
            if_kill = if_req_valid & if_req_ready;
        end else if (~misalign_exc & if_req_valid & if_req_ready) begin
            pc_n = pc + INST_BYTES;
        end
    end
endmodule
